// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS bit
// positions, serial FSM encodings and the divider floor.
// Pure declarations; no latency or backpressure of its own.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_IDLE   = 1;
  localparam int ST_RX_AVAIL  = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_TX_OVF    = 5;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // The RX half-bit wait needs at least two clocks, hence the floor.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// picorv32-style native bus slice seen by the UART: select, word address,
// strobes and write data in; registered read data and a ready pulse out.
// One wait state per access; the master holds cs until ready.
interface uart_mmio_if;
  logic        cs;
  logic [1:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output cs, addr, wstrb, wdata, input rdata, ready);
  modport slave  (input cs, addr, wstrb, wdata, output rdata, ready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
// dout shows the head entry combinationally; push/pop take effect next edge.
// Push and pop in one cycle both succeed even when full; pop on empty is ignored.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q];

  // Storage array: written on accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO into serialiser, RX deserialiser into a holding
// register (or an RX FIFO when UART_RX_FIFO_EN is defined). Bus latency: 1 wait state.
// Backpressure: none; full TX FIFO drops writes (tx_ovf), full RX buffer drops bytes (rx_ovr).
module uart_mmio
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd217
) (
  input  logic       clk,
  input  logic       rst,
  uart_mmio_if.slave bus,
  input  logic       rx,
  output logic       tx
);
  logic        ready_q, access, wr, rd;
  logic [31:0] rdata_q, rdata_d, status;
  logic [15:0] div_q, div_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_idle, tx_last;
  logic [7:0]  tx_dout;
  logic        rx_pop, rx_avail, rx_store, rx_ferr, rx_drop, rx_fall, rx_half, rx_last;
  logic [7:0]  rx_byte;
  logic        unused_bits;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q;

  // Side effects fire only in the cycle that raises ready.
  assign access    = bus.cs & ~ready_q;
  assign wr        = access & (|bus.wstrb);
  assign rd        = access & ~(|bus.wstrb);
  assign tx_push   = wr & (bus.addr == REG_DATA) & bus.wstrb[0];
  assign rx_pop    = rd & (bus.addr == REG_DATA) & rx_avail;
  assign tx_idle   = tx_empty & (tx_state_q == TX_IDLE);
  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign tx        = tx_q;
  assign unused_bits = &{1'b0, bus.wdata[31:16], bus.wstrb[3:2]};

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.wdata[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

`ifdef UART_RX_FIFO_EN
  logic rx_full, rx_empty;
  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_store), .pop(rx_pop), .din(rx_sh_q),
    .dout(rx_byte), .full(rx_full), .empty(rx_empty)
  );
  assign rx_avail = ~rx_empty;
  assign rx_drop  = rx_store & rx_full & ~rx_pop;
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;
  // Single-byte holding register; a read in the same cycle frees room for the new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (rx_store && (!hold_vld_q || rx_pop)) begin
      hold_q     <= rx_sh_q;
      hold_vld_q <= 1'b1;
    end else if (rx_pop) begin
      hold_vld_q <= 1'b0;
    end
  end
  assign rx_byte  = hold_q;
  assign rx_avail = hold_vld_q;
  assign rx_drop  = rx_store & hold_vld_q & ~rx_pop;
`endif

  // STATUS word assembled from live state and sticky flags.
  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_IDLE]    = tx_idle;
    status[ST_RX_AVAIL]   = rx_avail;
    status[ST_RX_OVR]     = rx_ovr_q;
    status[ST_FRAME_ERR]  = frame_err_q;
    status[ST_TX_OVF]     = tx_ovf_q;
  end

  // Register reads, writes and sticky flags; clears apply before new sets.
  always_comb begin
    rdata_d     = rdata_q;
    div_d       = div_q;
    tx_ovf_d    = tx_ovf_q;
    rx_ovr_d    = rx_ovr_q;
    frame_err_d = frame_err_q;
    if (rd) begin
      case (bus.addr)
        REG_DATA:   rdata_d = rx_avail ? {24'b0, rx_byte} : 32'h8000_0000;
        REG_STATUS: rdata_d = status;
        REG_DIV:    rdata_d = {16'b0, div_q};
        default:    rdata_d = '0;
      endcase
    end
    if (wr && bus.addr == REG_STATUS && bus.wstrb[0]) begin
      if (bus.wdata[ST_RX_OVR])    rx_ovr_d    = 1'b0;
      if (bus.wdata[ST_FRAME_ERR]) frame_err_d = 1'b0;
      if (bus.wdata[ST_TX_OVF])    tx_ovf_d    = 1'b0;
    end
    if (wr && bus.addr == REG_DIV)
      div_d = clamp_div({bus.wstrb[1] ? bus.wdata[15:8] : div_q[15:8],
                         bus.wstrb[0] ? bus.wdata[7:0]  : div_q[7:0]});
    if (tx_push && tx_full && !tx_pop) tx_ovf_d    = 1'b1;
    if (rx_drop)                       rx_ovr_d    = 1'b1;
    if (rx_ferr)                       frame_err_d = 1'b1;
  end

  // Bus and register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      div_q       <= DEFAULT_DIV;
      tx_ovf_q    <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ready_q     <= bus.cs & ~ready_q;
      rdata_q     <= rdata_d;
      div_q       <= div_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovr_q    <= rx_ovr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign tx_last = (tx_cnt_q == tx_div_q - 16'd1);

  // TX next state: each state lasts the divider latched at frame start.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_div_d   = tx_div_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE:  tx_cnt_d = '0;
      TX_START: if (tx_last) begin
        tx_state_d = TX_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_sh_q[0];
      end
      TX_DATA:  if (tx_last) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_d     = tx_sh_q[1];
        end
      end
      TX_STOP:  if (tx_last) begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
      end
      default:  tx_state_d = TX_IDLE;
    endcase
    // Start a frame from IDLE, or straight from the end of STOP with no gap.
    if ((tx_state_q == TX_IDLE || (tx_state_q == TX_STOP && tx_last)) && !tx_empty) begin
      tx_pop     = 1'b1;
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_div_d   = div_q;
      tx_sh_d    = tx_dout;
      tx_d       = 1'b0;
    end
  end

  // TX state register; tx line idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEFAULT_DIV;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_half = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
  assign rx_last = (rx_cnt_q == rx_div_q - 16'd1);

  // RX next state: recheck start at half a bit, then sample at bit centres.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_div_d   = rx_div_q;
    rx_store   = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_div_d   = div_q;
        end
      end
      RX_START: if (rx_half) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_last) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_last) begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
        rx_store   = rx_s2_q;
        rx_ferr    = ~rx_s2_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX synchroniser (reset to idle-high) and RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DEFAULT_DIV;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: bus register access, TX waveform and streaming,
// RX receive, framing error, overrun, divider clamp, glitch rejection and reset.
module tb_uart_mmio;
  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_DIV = 2'd2;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] cap_q [20];
  logic       cap_stop [20];
  int         cap_n;

  uart_mmio_if bus_if ();

  uart_mmio #(.FIFO_DEPTH(16), .DEFAULT_DIV(16'd217)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic bus_xfer(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] q);
    int n;
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.addr = a; bus_if.wstrb = s; bus_if.wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (bus_if.ready !== 1'b1 && n < 8);
    if (bus_if.ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%0d ready=%b required 1", a, bus_if.ready);
    end
    q = bus_if.rdata;
    bus_if.cs = 1'b0; bus_if.wstrb = 4'h0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus_xfer(a, 4'hF, d, q);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] q);
    bus_xfer(a, 4'h0, 32'h0, q);
  endtask

  // Capture back-to-back frames sampling at bit centres without resyncing, so any
  // idle gap between frames shows up as a missing start bit.
  task automatic tx_capture(input int div, input int max_frames);
    int n;
    logic [7:0] b;
    cap_n = 0;
    n = 0;
    while (tx !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    if (tx !== 1'b0) begin
      checks++; errors++;
      $display("FAIL tx_start_timeout tx=%b required 0", tx);
      return;
    end
    repeat (div / 2) @(negedge clk);
    for (int f = 0; f < max_frames; f++) begin
      if (tx !== 1'b0) break;
      for (int i = 0; i < 8; i++) begin
        repeat (div) @(negedge clk);
        b[i] = tx;
      end
      repeat (div) @(negedge clk);
      cap_stop[f] = tx;
      cap_q[f] = b;
      cap_n++;
      repeat (div) @(negedge clk);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int div);
    @(negedge clk);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (div) @(negedge clk);
    end
    rx = stop;
    repeat (div) @(negedge clk);
    rx = 1'b1;
    repeat (div) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] q;
    bus_if.cs = 1'b0; bus_if.addr = 2'd0; bus_if.wstrb = 4'h0; bus_if.wdata = 32'h0;
    rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (bus_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus_if.ready); end
    checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus_if.rdata); end
    rst = 1'b0;
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL reset_status got=%h exp=00000002", q); end
    bus_rd(A_DIV, q);
    checks++; if (q !== 32'd217) begin errors++; $display("FAIL reset_div got=%0d exp=217", q); end
    bus_rd(A_DATA, q);
    checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL reset_data_empty got=%h exp=80000000", q); end
  endtask

  task automatic test_tx_byte();
    logic [31:0] q;
    logic [9:0]  frame;
    int n;
    frame = {1'b1, 8'h55, 1'b0};
    bus_wr(A_DIV, 32'd4);
    bus_wr(A_DATA, 32'h55);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (tx !== frame[c / 4]) begin
        errors++; $display("FAIL tx_wave clk=%0d got=%b exp=%b", c, tx, frame[c / 4]);
      end
      @(negedge clk);
    end
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL tx_idle_after got=%h exp=00000002", q); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q;
    logic [31:0] stq;
    stq = 32'h0;
    fork
      begin
        for (int i = 0; i < 18; i++) bus_wr(A_DATA, 32'h10 + i);
        bus_rd(A_STAT, stq);
      end
      tx_capture(4, 20);
    join
    checks++; if (stq[0] !== 1'b1) begin errors++; $display("FAIL b2b_tx_full got=%b exp=1", stq[0]); end
    checks++; if (cap_n != 17) begin errors++; $display("FAIL b2b_frames got=%0d exp=17", cap_n); end
    for (int f = 0; f < 17 && f < cap_n; f++) begin
      checks++;
      if (cap_q[f] !== 8'(8'h10 + f) || cap_stop[f] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_byte%0d got=%h stop=%b exp=%h stop=1", f, cap_q[f], cap_stop[f], 8'(8'h10 + f));
      end
    end
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h22) begin errors++; $display("FAIL b2b_tx_ovf got=%h exp=00000022", q); end
    bus_wr(A_STAT, 32'h20);
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL b2b_ovf_clear got=%h exp=00000002", q); end
  endtask

  task automatic test_rx_byte();
    logic [31:0] q;
    bus_wr(A_DIV, 32'd8);
    rx_send(8'hA3, 1'b1, 8);
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h6) begin errors++; $display("FAIL rx_avail got=%h exp=00000006", q); end
    bus_rd(A_DATA, q);
    checks++; if (q !== 32'h0000_00A3) begin errors++; $display("FAIL rx_data got=%h exp=000000a3", q); end
    bus_rd(A_DATA, q);
    checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL rx_data_empty got=%h exp=80000000", q); end
  endtask

  task automatic test_frame_err();
    logic [31:0] q;
    rx_send(8'h5A, 1'b0, 8);
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h12) begin errors++; $display("FAIL frame_err_set got=%h exp=00000012", q); end
    bus_wr(A_STAT, 32'h10);
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL frame_err_clear got=%h exp=00000002", q); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] q;
    int n;
    for (int i = 0; i < 17; i++) rx_send(8'(8'h40 + i), 1'b1, 8);
    bus_rd(A_STAT, q);
    checks++; if (q[3:2] !== 2'b11) begin errors++; $display("FAIL rx_ovr_set got=%b exp=11", q[3:2]); end
    bus_rd(A_DATA, q);
    checks++; if (q !== 32'h40) begin errors++; $display("FAIL rx_first_intact got=%h exp=00000040", q); end
    n = 0;
    do begin bus_rd(A_DATA, q); n++; end while (q !== 32'h8000_0000 && n < 20);
    checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL rx_drain got=%h exp=80000000", q); end
    bus_wr(A_STAT, 32'h08);
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL rx_ovr_clear got=%h exp=00000002", q); end
  endtask

  task automatic test_div_clamp_glitch();
    logic [31:0] q;
    bus_wr(A_DIV, 32'd2);
    bus_rd(A_DIV, q);
    checks++; if (q !== 32'd4) begin errors++; $display("FAIL div_clamp got=%0d exp=4", q); end
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (20) @(negedge clk);
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL glitch_status got=%h exp=00000002", q); end
    bus_rd(A_DATA, q);
    checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL glitch_data got=%h exp=80000000", q); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] q;
    int lows;
    bus_wr(A_DATA, 32'hF0);
    repeat (10) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midtx_busy got=%b exp=0", tx); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midtx_rst_tx got=%b exp=1", tx); end
    checks++; if (bus_if.ready !== 1'b0) begin errors++; $display("FAIL midtx_rst_ready got=%b exp=0", bus_if.ready); end
    checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("FAIL midtx_rst_rdata got=%h exp=0", bus_if.rdata); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL midtx_frame_lost low_clocks=%0d exp=0", lows); end
    bus_rd(A_DIV, q);
    checks++; if (q !== 32'd217) begin errors++; $display("FAIL midtx_div got=%0d exp=217", q); end
    bus_rd(A_STAT, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL midtx_status got=%h exp=00000002", q); end
  endtask

  initial begin
    test_reset();
    test_tx_byte();
    test_back_to_back();
    test_rx_byte();
    test_frame_err();
    test_rx_overrun();
    test_div_clamp_glitch();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
